// File: rtl/mem_port_arbiter_if.sv
// Shared bus bundle for mem_port_arbiter: fetch port, data port and backing-memory port.
// The arbiter connects through the master modport and its environment through the slave modport.
interface mem_port_arbiter_if;
   logic        I_REQ;
   logic [31:0] I_ADDR;
   logic [31:0] I_RDATA;
   logic        I_ACK;

   logic        D_REQ;
   logic        D_WE;
   logic [31:0] D_ADDR;
   logic [31:0] D_WDATA;
   logic [1:0]  D_SIZE;
   logic [31:0] D_RDATA;
   logic        D_ACK;

   logic        M_REQ;
   logic        M_WE;
   logic [31:0] M_ADDR;
   logic [31:0] M_WDATA;
   logic [1:0]  M_SIZE;
   logic [31:0] M_RDATA;
   logic        M_ACK;

   modport master (
      input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, M_RDATA, M_ACK,
      output I_RDATA, I_ACK, D_RDATA, D_ACK, M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE
   );

   modport slave (
      output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, M_RDATA, M_ACK,
      input  I_RDATA, I_ACK, D_RDATA, D_ACK, M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one backing-memory port; data has priority.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic               CLK,
   input  logic               RST,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, I_XFER, D_XFER, RESP} state_t;

   state_t state;
   logic   starve_hit;
   logic   grant_d;

   if (STARVE_LIMIT < 1) begin : g_limit_check
      $error("STARVE_LIMIT must be at least 1");
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_cnt;

   assign starve_hit = bus.I_REQ && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
   assign starve_hit = 1'b0;
`endif

   assign grant_d = bus.D_REQ && !starve_hit;

   // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         bus.M_REQ   <= 1'b0;
         bus.M_WE    <= 1'b0;
         bus.M_ADDR  <= '0;
         bus.M_WDATA <= '0;
         bus.M_SIZE  <= '0;
         bus.I_ACK   <= 1'b0;
         bus.D_ACK   <= 1'b0;
         bus.I_RDATA <= '0;
         bus.D_RDATA <= '0;
`ifdef ARB_STARVE_GUARD_EN
         starve_cnt  <= '0;
`endif
      end else begin
         bus.I_ACK <= 1'b0;
         bus.D_ACK <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state       <= D_XFER;
                  bus.M_REQ   <= 1'b1;
                  bus.M_WE    <= bus.D_WE;
                  bus.M_ADDR  <= bus.D_ADDR;
                  bus.M_WDATA <= bus.D_WDATA;
                  bus.M_SIZE  <= bus.D_SIZE;
`ifdef ARB_STARVE_GUARD_EN
                  if (!bus.I_REQ)
                     starve_cnt <= '0;
                  else if (starve_cnt != CNT_W'(STARVE_LIMIT))
                     starve_cnt <= starve_cnt + 1'b1;
`endif
               end else if (bus.I_REQ) begin
                  // Fetches are always full-word reads.
                  state       <= I_XFER;
                  bus.M_REQ   <= 1'b1;
                  bus.M_WE    <= 1'b0;
                  bus.M_ADDR  <= bus.I_ADDR;
                  bus.M_WDATA <= '0;
                  bus.M_SIZE  <= 2'b10;
`ifdef ARB_STARVE_GUARD_EN
                  starve_cnt  <= '0;
`endif
               end
            end
            I_XFER: begin
               if (bus.M_ACK) begin
                  state       <= RESP;
                  bus.M_REQ   <= 1'b0;
                  bus.I_RDATA <= bus.M_RDATA;
                  bus.I_ACK   <= 1'b1;
               end
            end
            D_XFER: begin
               if (bus.M_ACK) begin
                  state       <= RESP;
                  bus.M_REQ   <= 1'b0;
                  bus.D_RDATA <= bus.M_RDATA;
                  bus.D_ACK   <= 1'b1;
               end
            end
            // The ACK cycle ignores requests, so a requester still holding REQ is not re-granted.
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed expectations for latency, grant order, reset abort and starvation.
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.master)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_s(input string name, input string act, input string exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0050_0093 : a * 3 + 32'h1111;
   endfunction

   // Backing memory: acks on the mem_delay-th cycle of M_REQ; stray_ack injects an unsolicited ack.
   int mem_delay = 1;
   bit stray_ack = 1'b0;
   initial begin
      int cnt = 0;
      bus.M_ACK   = 1'b0;
      bus.M_RDATA = '0;
      forever begin
         @(posedge CLK);
         #2;
         if (bus.M_REQ) begin
            cnt++;
            bus.M_ACK = (cnt == mem_delay);
            if (cnt == mem_delay) bus.M_RDATA = mem_data(bus.M_ADDR);
         end else begin
            cnt = 0;
            bus.M_ACK = stray_ack;
            if (stray_ack) bus.M_RDATA = 32'hBAD0_BAD0;
         end
      end
   end

   // Observed-transaction statistics
   int          n_iack, n_dack, n_mreq, n_field_chg;
   string       glog;
   logic        prev_mreq = 1'b0;
   logic [31:0] rise_addr, rise_wdata;
   logic        rise_we;
   logic [1:0]  rise_size;

   task automatic clear_stats();
      n_iack = 0; n_dack = 0; n_mreq = 0; n_field_chg = 0;
      glog = "";
   endtask

   // Reference model: the transaction in flight, the pending ACK and the register images.
   bit          mdl_valid = 1'b0;
   bit          busy = 1'b0, busy_d = 1'b0;
   int          ack_owner = 0;
   int          starve = 0;
   logic        e_we;
   logic [31:0] e_addr, e_wdata, e_ird, e_drd;
   logic [1:0]  e_size;

   initial begin
      forever begin
         @(negedge CLK);
         if (bus.M_REQ) begin
            n_mreq++;
            if (!prev_mreq) begin
               rise_addr = bus.M_ADDR; rise_wdata = bus.M_WDATA;
               rise_we = bus.M_WE; rise_size = bus.M_SIZE;
               if (bus.M_ADDR < 32'h4000) glog = {glog, "I"};
               else if (bus.M_WE) glog = {glog, "W"};
               else glog = {glog, "D"};
            end else if (bus.M_ADDR !== rise_addr || bus.M_WDATA !== rise_wdata ||
                         bus.M_WE !== rise_we || bus.M_SIZE !== rise_size) begin
               n_field_chg++;
            end
         end
         prev_mreq = bus.M_REQ;
         if (bus.I_ACK) n_iack++;
         if (bus.D_ACK) n_dack++;

         if (mdl_valid) begin
            check("M_REQ", {31'd0, bus.M_REQ}, {31'd0, busy});
            check("M_ADDR", bus.M_ADDR, e_addr);
            check("M_WDATA", bus.M_WDATA, e_wdata);
            check("M_WE", {31'd0, bus.M_WE}, {31'd0, e_we});
            check("M_SIZE", {30'd0, bus.M_SIZE}, {30'd0, e_size});
            check("I_ACK", {31'd0, bus.I_ACK}, (ack_owner == 1) ? 32'd1 : 32'd0);
            check("D_ACK", {31'd0, bus.D_ACK}, (ack_owner == 2) ? 32'd1 : 32'd0);
            check("I_RDATA", bus.I_RDATA, e_ird);
            check("D_RDATA", bus.D_RDATA, e_drd);
         end

         if (RST) begin
            mdl_valid = 1'b1; busy = 1'b0; ack_owner = 0; starve = 0;
            e_we = 1'b0; e_addr = '0; e_wdata = '0; e_size = '0; e_ird = '0; e_drd = '0;
         end else if (mdl_valid) begin
            if (ack_owner != 0) begin
               ack_owner = 0;
            end else if (busy) begin
               if (bus.M_ACK) begin
                  if (busy_d) e_drd = bus.M_RDATA; else e_ird = bus.M_RDATA;
                  ack_owner = busy_d ? 2 : 1;
                  busy = 1'b0;
               end
            end else if (bus.D_REQ && !(GUARD && bus.I_REQ && starve == LIMIT)) begin
               busy = 1'b1; busy_d = 1'b1;
               e_we = bus.D_WE; e_addr = bus.D_ADDR; e_wdata = bus.D_WDATA; e_size = bus.D_SIZE;
               starve = bus.I_REQ ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
            end else if (bus.I_REQ) begin
               busy = 1'b1; busy_d = 1'b0;
               e_we = 1'b0; e_addr = bus.I_ADDR; e_wdata = '0; e_size = 2'b10;
               starve = 0;
            end
         end
      end
   end

   // Holds each REQ through its ACK cycle and drops it on the following cycle.
   task automatic run_txn(input int budget, output int ack_at);
      int n = 0;
      bit i_seen = 1'b0, d_seen = 1'b0;
      ack_at = -1;
      while ((bus.I_REQ || bus.D_REQ) && n < budget) begin
         tick();
         n++;
         if (i_seen) bus.I_REQ = 1'b0;
         if (d_seen) bus.D_REQ = 1'b0;
         i_seen = bus.I_ACK;
         d_seen = bus.D_ACK;
         if ((i_seen || d_seen) && ack_at < 0) ack_at = n;
      end
      check("handshake timeout", {31'd0, bus.I_REQ | bus.D_REQ}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int at;
      RST = 1'b1;
      bus.I_REQ = 1'b0; bus.I_ADDR = '0;
      bus.D_REQ = 1'b0; bus.D_WE = 1'b0; bus.D_ADDR = '0; bus.D_WDATA = '0; bus.D_SIZE = '0;
      clear_stats();
      repeat (2) tick();
      check("reset M_REQ", {31'd0, bus.M_REQ}, 32'd0);
      check("reset M_ADDR", bus.M_ADDR, 32'd0);
      check("reset M_SIZE", {30'd0, bus.M_SIZE}, 32'd0);
      check("reset I_RDATA", bus.I_RDATA, 32'd0);
      check("reset D_RDATA", bus.D_RDATA, 32'd0);
      RST = 1'b0;
      tick();

      // Single fetch, memory acks on the first M_REQ cycle
      clear_stats();
      mem_delay = 1;
      bus.I_ADDR = 32'h100; bus.I_REQ = 1'b1;
      run_txn(20, at);
      check_s("fetch grant order", glog, "I");
      check("fetch M_ADDR", rise_addr, 32'h100);
      check("fetch M_WE", {31'd0, rise_we}, 32'd0);
      check("fetch M_SIZE", {30'd0, rise_size}, 32'd2);
      check("fetch I_RDATA", bus.I_RDATA, 32'h0050_0093);
      check("fetch I_ACK pulses", n_iack, 1);
      check("fetch D_ACK pulses", n_dack, 0);
      check("fetch ack latency", at, 2);
      check("fetch M_REQ cycles", n_mreq, 1);

      // Simultaneous requests: data write first, then fetch
      clear_stats();
      bus.I_ADDR = 32'h200;
      bus.D_WE = 1'b1; bus.D_ADDR = 32'h8000; bus.D_WDATA = 32'hDEAD_BEEF; bus.D_SIZE = 2'b10;
      bus.I_REQ = 1'b1; bus.D_REQ = 1'b1;
      run_txn(40, at);
      check_s("collide grant order", glog, "WI");
      check("collide first ack", at, 2);
      check("collide D_ACK pulses", n_dack, 1);
      check("collide I_ACK pulses", n_iack, 1);
      check("collide D_RDATA", bus.D_RDATA, 32'h0001_9111);
      check("collide I_RDATA", bus.I_RDATA, 32'h0000_1711);
      check("collide fetch M_WDATA", rise_wdata, 32'h0);

      // Slow memory: five-cycle transfer with stable fields
      clear_stats();
      mem_delay = 5;
      bus.D_WE = 1'b1; bus.D_ADDR = 32'h4040; bus.D_WDATA = 32'h1234_5678; bus.D_SIZE = 2'b01;
      bus.D_REQ = 1'b1;
      run_txn(40, at);
      check_s("slow grant order", glog, "W");
      check("slow M_REQ cycles", n_mreq, 5);
      check("slow field changes", n_field_chg, 0);
      check("slow M_WDATA", rise_wdata, 32'h1234_5678);
      check("slow M_SIZE", {30'd0, rise_size}, 32'd1);
      check("slow ack latency", at, 6);
      check("slow D_RDATA", bus.D_RDATA, 32'h0000_D1D1);

      // Reset during the second D_XFER cycle, then a late memory ack
      clear_stats();
      bus.D_WE = 1'b0; bus.D_ADDR = 32'h4080; bus.D_REQ = 1'b1;
      tick();
      tick();
      check("abort M_REQ before reset", {31'd0, bus.M_REQ}, 32'd1);
      RST = 1'b1; bus.D_REQ = 1'b0;
      tick();
      check("abort M_REQ after reset", {31'd0, bus.M_REQ}, 32'd0);
      check("abort D_ACK after reset", {31'd0, bus.D_ACK}, 32'd0);
      RST = 1'b0; stray_ack = 1'b1;
      tick();
      stray_ack = 1'b0;
      repeat (4) tick();
      check("abort D_ACK pulses", n_dack, 0);
      check("abort D_RDATA", bus.D_RDATA, 32'd0);
      check("abort M_REQ idle", {31'd0, bus.M_REQ}, 32'd0);
      check_s("abort grant order", glog, "D");

      // Memory ack arriving during the ACK cycle, REQ held through it
      clear_stats();
      mem_delay = 1;
      bus.I_ADDR = 32'h300; bus.I_REQ = 1'b1;
      tick();
      tick();
      check("resp I_ACK", {31'd0, bus.I_ACK}, 32'd1);
      stray_ack = 1'b1;
      tick();
      stray_ack = 1'b0; bus.I_REQ = 1'b0;
      repeat (3) tick();
      check("resp I_RDATA", bus.I_RDATA, 32'h0000_1A11);
      check("resp I_ACK pulses", n_iack, 1);
      check_s("resp grant order", glog, "I");

      // Both requesters held continuously for ten back-to-back transactions
      clear_stats();
      bus.D_WE = 1'b0; bus.D_ADDR = 32'h4100; bus.I_ADDR = 32'h400;
      bus.D_REQ = 1'b1; bus.I_REQ = 1'b1;
      repeat (30) tick();
      bus.D_REQ = 1'b0; bus.I_REQ = 1'b0;
      repeat (3) tick();
      check_s("starve grant order", glog, GUARD ? "DDDDIDDDDI" : "DDDDDDDDDD");
      check("starve I_ACK pulses", n_iack, GUARD ? 2 : 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while fetch waits (starvation guard only).
REQ-002 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports I_REQ in 1 and I_ADDR in 32: fetch request, held stable until I_ACK.
REQ-005 SHALL have ports I_RDATA out 32 and I_ACK out 1: fetch read data and one-cycle completion pulse.
REQ-006 SHALL have ports D_REQ in 1, D_WE in 1, D_ADDR in 32, D_WDATA in 32 and D_SIZE in 2: data request, held stable until D_ACK.
REQ-007 SHALL have ports D_RDATA out 32 and D_ACK out 1: data read data and one-cycle completion pulse.
REQ-008 SHALL have ports M_REQ out 1, M_WE out 1, M_ADDR out 32, M_WDATA out 32 and M_SIZE out 2: shared backing-memory request.
REQ-009 SHALL have ports M_RDATA in 32 and M_ACK in 1: memory read data, valid in the single cycle M_ACK is high.

Function
REQ-010 SHALL implement FSM states IDLE, I_XFER, D_XFER, RESP.
REQ-011 IDLE: D_REQ high (and no starvation override) -> D_XFER; else I_REQ high -> I_XFER; else stay.
REQ-012 On leaving IDLE, SHALL latch the winner's address/we/wdata/size into M_* registers; fetch grant forces M_WE=0, M_SIZE=2'b10, M_WDATA=0.
REQ-013 M_REQ SHALL be high exactly while in I_XFER or D_XFER; M_* fields SHALL remain constant for the whole transfer.
REQ-014 In I_XFER/D_XFER with M_ACK high: SHALL capture M_RDATA into I_RDATA or D_RDATA (the owner's only) and go to RESP.
REQ-015 In I_XFER/D_XFER with M_ACK low: SHALL stay, no timeout.
REQ-016 RESP: SHALL pulse the owner's I_ACK or D_ACK for exactly one cycle, then go to IDLE unconditionally.
REQ-017 I_RDATA/D_RDATA SHALL hold their last captured value until overwritten by their own next read; data writes SHALL also update D_RDATA with M_RDATA.
REQ-018 Latency: request seen in IDLE at cycle 0 -> M_REQ cycle 1 -> M_ACK earliest cycle 1 -> ACK cycle 2; min period 3 cycles per transaction.
REQ-019 RESP state SHALL guarantee a requester still holding REQ during its ACK cycle is not granted twice.
REQ-020 M_ACK arriving in IDLE or RESP SHALL be ignored.
REQ-021 I_ACK and D_ACK SHALL never be high in the same cycle.
REQ-022 Simultaneous I_REQ and D_REQ in IDLE: data wins unless REQ-030 override applies.

Reset
REQ-023 RST high at an edge SHALL force IDLE regardless of state, including mid-transfer.
REQ-024 Reset values: M_REQ=0, M_WE=0, M_ADDR=0, M_WDATA=0, M_SIZE=0, I_ACK=0, D_ACK=0, I_RDATA=0, D_RDATA=0, starvation counter=0.
REQ-025 A transfer aborted by reset SHALL produce no ACK; the backing memory drops its outstanding request when M_REQ falls.

Configuration
REQ-026 Macro ARB_STARVE_GUARD_EN SHALL compile the starvation guard in; absent, arbitration is strict data priority and STARVE_LIMIT is unused.
REQ-027 With guard: counter width SHALL be $clog2(STARVE_LIMIT+1).
REQ-028 With guard: counter SHALL increment on each data grant taken while I_REQ is high, saturating at STARVE_LIMIT.
REQ-029 With guard: counter SHALL clear on any fetch grant, or on a data grant with I_REQ low.
REQ-030 With guard: counter==STARVE_LIMIT and I_REQ high in IDLE SHALL grant fetch even if D_REQ is high.

Verification
REQ-031 I_REQ=1, I_ADDR=0x100, M_ACK one cycle after M_REQ with M_RDATA=0x00500093 -> M_ADDR=0x100, M_WE=0, I_RDATA=0x00500093, single I_ACK pulse, D_ACK never set.
REQ-032 I_REQ and D_REQ both rise in the same cycle, D_WE=1, D_ADDR=0x8000, D_WDATA=0xDEADBEEF -> data transaction first (M_WE=1), D_ACK, then fetch transaction, then I_ACK.
REQ-033 Memory with 5-cycle M_ACK delay -> M_REQ high 5 cycles with M_ADDR/M_WDATA constant, ACK 1 cycle after M_ACK.
REQ-034 RST pulsed on the 2nd cycle of D_XFER -> next cycle IDLE, M_REQ=0, no D_ACK; a late M_ACK is ignored.
REQ-035 With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, D_REQ and I_REQ held high -> grants D,D,D,D,I repeating; without macro -> I never granted while D_REQ high.
